// File: rtl/control_towerplacer.sv
// ---------------------------------------------------------------------------
// control_towerplacer
//
// Control FSM for the tower-placement screen. It walks a cursor square over
// a GRID_COLS x GRID_ROWS board, erases/redraws the cursor square as it moves
// and draws towers on request. All drawing work is done by an external
// datapath; this block only sequences it and waits on its feedback.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   key_right/down/place   user requests (synchronised, level); edge detected
//   enable                 placement mode; key edges are ignored when low
//   square_done            cursor square finished drawing
//   erase_square_done      cursor square finished erasing
//   tower_done             tower finished drawing
//   valid                  datapath accepted the cursor move
//   top_left .. erase_square_tower
//                          one-hot (or none) datapath controls, Moore decodes
//   busy                   high whenever the FSM is not idle
//   occupied               cell under the cursor already holds a tower
//   tower_count            towers placed since reset (saturates at MAX_TOWERS)
//   place_reject           one-cycle pulse when a placement is refused
// ---------------------------------------------------------------------------
module control_towerplacer #(
  parameter int GRID_COLS  = 8,
  parameter int GRID_ROWS  = 6,
  parameter int MAX_TOWERS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_place,
  input  logic       enable,
  input  logic       square_done,
  input  logic       erase_square_done,
  input  logic       tower_done,
  input  logic       valid,
  output logic       top_left,
  output logic       draw_square,
  output logic       move_right,
  output logic       move_down,
  output logic       move_right_wait,
  output logic       move_down_wait,
  output logic       draw_tower,
  output logic       erase_square_right,
  output logic       erase_square_down,
  output logic       erase_square_tower,
  output logic       busy,
  output logic       occupied,
  output logic [4:0] tower_count,
  output logic       place_reject
);

  localparam int CELLS = GRID_COLS * GRID_ROWS;
  localparam int CW    = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int RW    = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(GRID_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_ROWS - 1);
  localparam logic [4:0]    MAX_CNT  = 5'(MAX_TOWERS);

  typedef enum logic [3:0] {
    S_TOP_LEFT,
    S_DRAW_SQ,
    S_IDLE,
    S_ERASE_R,
    S_MOVE_R,
    S_MOVE_R_WAIT,
    S_ERASE_D,
    S_MOVE_D,
    S_MOVE_D_WAIT,
    S_ERASE_T,
    S_DRAW_T
  } state_t;

  state_t            state;
  logic              hold_q;    // 1 from the second cycle of a state onward
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CELLS-1:0]  bitmap;
  logic [2:0]        key_q;     // {place, down, right} history
  logic [2:0]        key_edge;
  logic [IW-1:0]     cell_idx;
  logic              place_ok;

  assign key_edge = {key_place, key_down, key_right} & ~key_q;
  assign cell_idx = IW'(row) * IW'(GRID_COLS) + IW'(col);
  assign occupied = bitmap[cell_idx];
  assign place_ok = !occupied && (tower_count < MAX_CNT);

  // Moore decodes of the state register
  assign top_left           = (state == S_TOP_LEFT);
  assign draw_square        = (state == S_DRAW_SQ);
  assign erase_square_right = (state == S_ERASE_R);
  assign erase_square_down  = (state == S_ERASE_D);
  assign erase_square_tower = (state == S_ERASE_T);
  assign move_right         = (state == S_MOVE_R);
  assign move_down          = (state == S_MOVE_D);
  assign move_right_wait    = (state == S_MOVE_R_WAIT);
  assign move_down_wait     = (state == S_MOVE_D_WAIT);
  assign draw_tower         = (state == S_DRAW_T);
  assign busy               = (state != S_IDLE);

  // hold_q defaults to 1 and is cleared on every transition, so a done input
  // can only end a drawing state from its second cycle onward.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_TOP_LEFT;
      hold_q       <= 1'b0;
      col          <= '0;
      row          <= '0;
      bitmap       <= '0;
      tower_count  <= '0;
      place_reject <= 1'b0;
      key_q        <= '0;
    end else begin
      key_q        <= {key_place, key_down, key_right};
      place_reject <= 1'b0;
      hold_q       <= 1'b1;
      case (state)
        S_TOP_LEFT: begin
          state  <= S_DRAW_SQ;
          hold_q <= 1'b0;
        end
        S_DRAW_SQ: begin
          if (hold_q && square_done) begin
            state  <= S_IDLE;
            hold_q <= 1'b0;
          end
        end
        S_IDLE: begin
          // Priority place > right > down; losing edges are simply consumed.
          if (enable) begin
            if (key_edge[2]) begin
              if (place_ok) begin
                state  <= S_ERASE_T;
                hold_q <= 1'b0;
              end else begin
                place_reject <= 1'b1;
              end
            end else if (key_edge[0]) begin
              state  <= S_ERASE_R;
              hold_q <= 1'b0;
            end else if (key_edge[1]) begin
              state  <= S_ERASE_D;
              hold_q <= 1'b0;
            end
          end
        end
        S_ERASE_R: begin
          if (hold_q && erase_square_done) begin
            state  <= S_MOVE_R;
            hold_q <= 1'b0;
          end
        end
        S_MOVE_R: begin
          if (valid) begin
            state  <= S_MOVE_R_WAIT;
            hold_q <= 1'b0;
            col    <= (col == COL_LAST) ? '0 : col + 1'b1;
          end
        end
        S_MOVE_R_WAIT: begin
          state  <= S_DRAW_SQ;
          hold_q <= 1'b0;
        end
        S_ERASE_D: begin
          if (hold_q && erase_square_done) begin
            state  <= S_MOVE_D;
            hold_q <= 1'b0;
          end
        end
        S_MOVE_D: begin
          if (valid) begin
            state  <= S_MOVE_D_WAIT;
            hold_q <= 1'b0;
            row    <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end
        end
        S_MOVE_D_WAIT: begin
          state  <= S_DRAW_SQ;
          hold_q <= 1'b0;
        end
        S_ERASE_T: begin
          if (hold_q && erase_square_done) begin
            state  <= S_DRAW_T;
            hold_q <= 1'b0;
          end
        end
        S_DRAW_T: begin
          if (hold_q && tower_done) begin
            state            <= S_DRAW_SQ;
            hold_q           <= 1'b0;
            bitmap[cell_idx] <= 1'b1;
            if (tower_count < MAX_CNT) tower_count <= tower_count + 5'd1;
          end
        end
        default: begin
          state  <= S_TOP_LEFT;
          hold_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_towerplacer.sv
module tb_control_towerplacer;

  localparam int GC = 8;
  localparam int GR = 6;
  localparam int MT = 16;

  localparam int C_NONE = 0, C_TL = 1, C_DSQ = 2, C_ER = 3, C_MR = 4, C_MRW = 5;
  localparam int C_ED = 6, C_MD = 7, C_MDW = 8, C_ET = 9, C_DT = 10;
  localparam int K_RIGHT = 0, K_DOWN = 1, K_PLACE = 2;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic key_right = 1'b0, key_down = 1'b0, key_place = 1'b0, enable = 1'b1;
  logic square_done = 1'b0, erase_square_done = 1'b0, tower_done = 1'b0, valid = 1'b0;
  logic top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait;
  logic draw_tower, erase_square_right, erase_square_down, erase_square_tower;
  logic busy, occupied, place_reject;
  logic [4:0] tower_count;
  logic [9:0] ctrl;

  control_towerplacer #(.GRID_COLS(GC), .GRID_ROWS(GR), .MAX_TOWERS(MT)) dut (
    .clk(clk), .resetn(resetn),
    .key_right(key_right), .key_down(key_down), .key_place(key_place),
    .enable(enable), .square_done(square_done),
    .erase_square_done(erase_square_done), .tower_done(tower_done), .valid(valid),
    .top_left(top_left), .draw_square(draw_square), .move_right(move_right),
    .move_down(move_down), .move_right_wait(move_right_wait),
    .move_down_wait(move_down_wait), .draw_tower(draw_tower),
    .erase_square_right(erase_square_right), .erase_square_down(erase_square_down),
    .erase_square_tower(erase_square_tower), .busy(busy), .occupied(occupied),
    .tower_count(tower_count), .place_reject(place_reject)
  );

  always #5 clk = ~clk;

  assign ctrl = {top_left, draw_square, move_right, move_down, move_right_wait,
                 move_down_wait, draw_tower, erase_square_right, erase_square_down,
                 erase_square_tower};

  int checks = 0, errors = 0;
  int lat = 1;
  int prev_code = -1, run_cnt = 0, multi_hot = 0;
  int trace[$], exp_q[$];
  bit timed_out;
  logic rej_s;
  bit exp_rej;
  int mcol, mrow, mcnt;
  bit mbmp[GC*GR];

  function automatic int code_now();
    if (top_left) return C_TL;
    if (draw_square) return C_DSQ;
    if (erase_square_right) return C_ER;
    if (move_right) return C_MR;
    if (move_right_wait) return C_MRW;
    if (erase_square_down) return C_ED;
    if (move_down) return C_MD;
    if (move_down_wait) return C_MDW;
    if (erase_square_tower) return C_ET;
    if (draw_tower) return C_DT;
    return C_NONE;
  endfunction

  // Datapath stand-in: raises the matching done/valid once the current
  // control has been active for lat cycles.
  always @(negedge clk) begin
    int c;
    c = code_now();
    if ($countones(ctrl) > 1) multi_hot++;
    if (c == prev_code) run_cnt++; else run_cnt = 1;
    prev_code = c;
    square_done       = (c == C_DSQ) && (run_cnt >= lat);
    erase_square_done = (c == C_ER || c == C_ED || c == C_ET) && (run_cnt >= lat);
    tower_done        = (c == C_DT) && (run_cnt >= lat);
    valid             = (c == C_MR || c == C_MD) && (run_cnt >= lat);
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    mcol = 0; mrow = 0; mcnt = 0;
    foreach (mbmp[i]) mbmp[i] = 1'b0;
  endfunction

  function automatic bit m_occ();
    return mbmp[mrow*GC + mcol];
  endfunction

  function automatic bit model_cmd(int kind);
    case (kind)
      K_RIGHT: mcol = (mcol + 1) % GC;
      K_DOWN:  mrow = (mrow + 1) % GR;
      default: begin
        if (m_occ() || mcnt >= MT) return 1'b1;
        mbmp[mrow*GC + mcol] = 1'b1;
        mcnt++;
      end
    endcase
    return 1'b0;
  endfunction

  function automatic void push_n(int c, int n);
    repeat (n) exp_q.push_back(c);
  endfunction

  // Expected visible control sequence for one accepted command.
  function automatic void expect_seq(int kind, bit rejected);
    int h;
    h = (lat < 2) ? 2 : lat;
    exp_q.delete();
    case (kind)
      K_RIGHT: begin push_n(C_ER, h); push_n(C_MR, lat); push_n(C_MRW, 1); push_n(C_DSQ, h); end
      K_DOWN:  begin push_n(C_ED, h); push_n(C_MD, lat); push_n(C_MDW, 1); push_n(C_DSQ, h); end
      default: if (!rejected) begin push_n(C_ET, h); push_n(C_DT, h); push_n(C_DSQ, h); end
    endcase
  endfunction

  function automatic int first_diff();
    int n;
    n = (trace.size() < exp_q.size()) ? trace.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (trace[i] != exp_q[i]) return i;
    if (trace.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    trace.delete();
    timed_out = 1'b0;
    while (busy === 1'b1) begin
      trace.push_back(code_now());
      @(negedge clk);
      n++;
      if (n > 400) begin timed_out = 1'b1; break; end
    end
  endtask

  task automatic cmd(int kind, logic [2:0] keys);
    @(negedge clk);
    {key_place, key_down, key_right} = keys;
    @(negedge clk);
    {key_place, key_down, key_right} = 3'b000;
    rej_s = place_reject;
    exp_rej = model_cmd(kind);
    expect_seq(kind, exp_rej);
    wait_idle();
  endtask

  task automatic release_reset();
    @(negedge clk);
    model_reset();
    resetn = 1'b1;
    exp_q.delete();
    exp_q.push_back(C_TL);
    push_n(C_DSQ, (lat < 2) ? 2 : lat);
    wait_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int d;
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ctrl !== 10'b1000000000 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_ctrl: ctrl=%b busy=%b, required ctrl=1000000000 busy=1", ctrl, busy);
    end
    checks++;
    if (tower_count !== 5'd0 || place_reject !== 1'b0) begin
      errors++; $display("FAIL reset_regs: count=%0d rej=%b, required 0/0", tower_count, place_reject);
    end
    lat = 3;
    release_reset();
    d = first_diff();
    checks++;
    if (d != -1 || timed_out) begin
      errors++; $display("FAIL reset_trace: diff at %0d len=%0d, required len=%0d", d, trace.size(), exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || occupied !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b occ=%b, required 0/0", busy, occupied);
    end
  endtask

  task automatic test_place();
    int d;
    lat = 1;
    cmd(K_PLACE, 3'b100);
    d = first_diff();
    checks++;
    if (d != -1 || timed_out) begin
      errors++; $display("FAIL place_trace: diff at %0d len=%0d, required len=%0d", d, trace.size(), exp_q.size());
    end
    checks++;
    if (tower_count !== 5'(mcnt) || occupied !== m_occ() || rej_s !== 1'b0) begin
      errors++; $display("FAIL place_state: count=%0d occ=%b rej=%b, required %0d/%b/0", tower_count, occupied, rej_s, mcnt, m_occ());
    end
    cmd(K_PLACE, 3'b100);
    checks++;
    if (rej_s !== 1'b1 || trace.size() != 0) begin
      errors++; $display("FAIL place_reject: rej=%b len=%0d, required 1/0", rej_s, trace.size());
    end
    @(negedge clk);
    checks++;
    if (place_reject !== 1'b0 || tower_count !== 5'd1) begin
      errors++; $display("FAIL reject_pulse: rej=%b count=%0d, required 0/1", place_reject, tower_count);
    end
  endtask

  task automatic test_right_wrap();
    int d;
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      cmd(K_RIGHT, 3'b001);
      d = first_diff();
      checks++;
      if (d != -1 || timed_out) begin
        errors++; $display("FAIL right_trace[%0d]: diff at %0d len=%0d, required len=%0d", i, d, trace.size(), exp_q.size());
      end
      checks++;
      if (occupied !== m_occ()) begin
        errors++; $display("FAIL right_occ[%0d]: occ=%b, required %b (col %0d)", i, occupied, m_occ(), mcol);
      end
    end
  endtask

  task automatic test_down_wrap();
    int d;
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, 3);
      cmd(K_DOWN, 3'b010);
      d = first_diff();
      checks++;
      if (d != -1 || timed_out) begin
        errors++; $display("FAIL down_trace[%0d]: diff at %0d len=%0d, required len=%0d", i, d, trace.size(), exp_q.size());
      end
      checks++;
      if (occupied !== m_occ()) begin
        errors++; $display("FAIL down_occ[%0d]: occ=%b, required %b (row %0d)", i, occupied, m_occ(), mrow);
      end
    end
  endtask

  task automatic test_held_key();
    int moves, n;
    logic prev;
    lat = 1;
    moves = 0; prev = 1'b0;
    @(negedge clk);
    key_right = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (erase_square_right && !prev) moves++;
      prev = erase_square_right;
    end
    key_right = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      if (erase_square_right && !prev) moves++;
      prev = erase_square_right;
      n++;
    end
    void'(model_cmd(K_RIGHT));
    checks++;
    if (moves != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL held_key: moves=%0d busy=%b, required 1/0", moves, busy);
    end
    checks++;
    if (occupied !== m_occ()) begin
      errors++; $display("FAIL held_occ: occ=%b, required %b", occupied, m_occ());
    end
  endtask

  task automatic test_priority();
    int d;
    lat = 2;
    cmd(K_PLACE, 3'b111);
    d = first_diff();
    checks++;
    if (d != -1 || timed_out) begin
      errors++; $display("FAIL prio_trace: diff at %0d len=%0d, required len=%0d", d, trace.size(), exp_q.size());
    end
    checks++;
    if (tower_count !== 5'(mcnt) || occupied !== 1'b1) begin
      errors++; $display("FAIL prio_state: count=%0d occ=%b, required %0d/1", tower_count, occupied, mcnt);
    end
    cmd(K_DOWN, 3'b010);
    checks++;
    if (occupied !== m_occ()) begin
      errors++; $display("FAIL prio_cursor: occ=%b, required %b", occupied, m_occ());
    end
  endtask

  task automatic test_enable();
    int busy_cnt, d;
    lat = 2;
    busy_cnt = 0;
    @(negedge clk);
    enable = 1'b0;
    key_right = 1'b1;
    @(negedge clk);
    key_right = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 0) begin
      errors++; $display("FAIL enable_off: busy cycles=%0d, required 0", busy_cnt);
    end
    enable = 1'b1;
    key_right = 1'b1;
    @(negedge clk);
    key_right = 1'b0;
    enable = 1'b0;
    void'(model_cmd(K_RIGHT));
    expect_seq(K_RIGHT, 1'b0);
    wait_idle();
    enable = 1'b1;
    d = first_diff();
    checks++;
    if (d != -1 || timed_out) begin
      errors++; $display("FAIL enable_drop_mid: diff at %0d len=%0d, required len=%0d", d, trace.size(), exp_q.size());
    end
  endtask

  task automatic test_drop_outside_idle();
    int busy_cnt;
    lat = 3;
    busy_cnt = 0;
    @(negedge clk); key_right = 1'b1;
    @(negedge clk); key_right = 1'b0;
    @(negedge clk); key_down = 1'b1;
    @(negedge clk); key_down = 1'b0;
    void'(model_cmd(K_RIGHT));
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 0 || timed_out) begin
      errors++; $display("FAIL drop_key: busy cycles after idle=%0d, required 0", busy_cnt);
    end
    checks++;
    if (occupied !== m_occ()) begin
      errors++; $display("FAIL drop_occ: occ=%b, required %b", occupied, m_occ());
    end
  endtask

  task automatic test_random();
    int kind, d;
    logic [2:0] keys;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      lat = $urandom_range(1, 4);
      keys = (kind == K_RIGHT) ? 3'b001 : (kind == K_DOWN) ? 3'b010 : 3'b100;
      cmd(kind, keys);
      d = first_diff();
      checks++;
      if (d != -1 || timed_out) begin
        errors++; $display("FAIL rand_trace[%0d]: kind=%0d lat=%0d diff at %0d len=%0d, required len=%0d", i, kind, lat, d, trace.size(), exp_q.size());
      end
      checks++;
      if (occupied !== m_occ() || tower_count !== 5'(mcnt) || rej_s !== exp_rej) begin
        errors++; $display("FAIL rand_state[%0d]: occ=%b count=%0d rej=%b, required %b/%0d/%b", i, occupied, tower_count, rej_s, m_occ(), mcnt, exp_rej);
      end
    end
    checks++;
    if (multi_hot != 0) begin
      errors++; $display("FAIL one_hot: multi-hot cycles=%0d, required 0", multi_hot);
    end
  endtask

  task automatic test_limit();
    int d;
    lat = 1;
    for (int g = 0; g < 300 && mcnt < MT; g++) begin
      if (!m_occ()) cmd(K_PLACE, 3'b100);
      else begin
        cmd(K_RIGHT, 3'b001);
        if (mcol == 0) cmd(K_DOWN, 3'b010);
      end
      d = first_diff();
      checks++;
      if (d != -1 || timed_out) begin
        errors++; $display("FAIL fill_trace[%0d]: diff at %0d len=%0d, required len=%0d", g, d, trace.size(), exp_q.size());
      end
    end
    checks++;
    if (tower_count !== 5'(MT)) begin
      errors++; $display("FAIL fill_count: count=%0d, required %0d", tower_count, MT);
    end
    for (int g = 0; g < 100 && m_occ(); g++) cmd(K_RIGHT, 3'b001);
    cmd(K_PLACE, 3'b100);
    checks++;
    if (rej_s !== 1'b1 || exp_rej !== 1'b1 || trace.size() != 0 || tower_count !== 5'(MT)) begin
      errors++; $display("FAIL limit_reject: rej=%b len=%0d count=%0d, required 1/0/%0d", rej_s, trace.size(), tower_count, MT);
    end
  endtask

  task automatic test_reset_mid();
    int n, d;
    lat = 3;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk);
    release_reset();
    @(negedge clk); key_place = 1'b1;
    @(negedge clk); key_place = 1'b0;
    n = 0;
    while (draw_tower !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (draw_tower !== 1'b1) begin
      errors++; $display("FAIL reach_drawt: draw_tower=%b, required 1", draw_tower);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (ctrl !== 10'b1000000000 || busy !== 1'b1 || tower_count !== 5'd0 || place_reject !== 1'b0) begin
      errors++; $display("FAIL reset_mid: ctrl=%b busy=%b count=%0d rej=%b, required 1000000000/1/0/0", ctrl, busy, tower_count, place_reject);
    end
    checks++;
    if (occupied !== 1'b0) begin
      errors++; $display("FAIL reset_mid_occ: occ=%b, required 0", occupied);
    end
    @(negedge clk);
    release_reset();
    d = first_diff();
    checks++;
    if (d != -1 || timed_out || occupied !== 1'b0 || tower_count !== 5'd0) begin
      errors++; $display("FAIL reset_mid_release: diff at %0d occ=%b count=%0d, required -1/0/0", d, occupied, tower_count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_place();
    test_right_wrap();
    test_down_wrap();
    test_held_key();
    test_priority();
    test_enable();
    test_drop_outside_idle();
    test_random();
    test_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
